// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

   // Responder FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   // Byte address bits below the word index.
   localparam int ADDR_LSB = 2;

   // Width of the board test value tap.
   localparam int TEST_W = 16;

   // Cause of the most recent response, for debug visibility.
   typedef logic [1:0] err_cause_t;
   localparam err_cause_t ERR_NONE  = 2'd0;
   localparam err_cause_t ERR_ALIGN = 2'd1;
   localparam err_cause_t ERR_RANGE = 2'd2;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, synchronous clear, combinational read
// port and a fixed tap on the low bits of word 0.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int ENTRIES    = 100,
   parameter int IDX_W      = 7
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [WORD_WIDTH-1:0] wr_data,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [WORD_WIDTH-1:0] rd_data,
   output logic [TEST_W-1:0]     word0_lo
);

   logic [WORD_WIDTH-1:0] mem [ENTRIES];

   // Clear every word on reset, otherwise write one word when enabled.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Indices past the last word read as zero rather than undefined.
   assign rd_data  = ({1'b0, rd_idx} < (IDX_W + 1)'(ENTRIES)) ? mem[rd_idx] : '0;
   assign word0_lo = mem[0][TEST_W-1:0];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the core's data port: one outstanding request,
// configurable wait states, registered response held until consumed.
//
// Handshake: a request transfers on a rising edge where Req_Valid=1 and
// Req_Ready=1; a response transfers on a rising edge where Rsp_Valid=1 and
// Rsp_Ready=1. Once Rsp_Valid is high, Rsp_RD and Rsp_Err stay stable until
// that transfer, and no new request is accepted until the responder is idle.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int WORD_WIDTH  = 32,
   parameter int ENTRIES     = 100,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  Req_Valid,
   output logic                  Req_Ready,
   input  logic                  Req_WE,
   input  logic [31:0]           Req_A,
   input  logic [WORD_WIDTH-1:0] Req_WD,
   output logic                  Rsp_Valid,
   input  logic                  Rsp_Ready,
   output logic [WORD_WIDTH-1:0] Rsp_RD,
   output logic                  Rsp_Err,
   output logic [TEST_W-1:0]     Test_Value,
   output dmem_state_e           dbg_state,
   output err_cause_t            dbg_err_cause
);

   localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int WIDX_W = 32 - ADDR_LSB;

   dmem_state_e           state, state_next;
   logic [CNT_W-1:0]      cnt, cnt_next;
   logic                  commit;
   logic                  use_in;

   logic                  lat_we;
   logic [31:0]           lat_a;
   logic [WORD_WIDTH-1:0] lat_wd;

   logic                  cmt_we;
   logic [31:0]           cmt_a;
   logic [WORD_WIDTH-1:0] cmt_wd;
   logic [WIDX_W-1:0]     cmt_word;
   logic                  err_align;
   logic                  err_range;
   logic                  cmt_err;
   err_cause_t            cmt_cause;

   logic [IDX_W-1:0]      arr_idx;
   logic [WORD_WIDTH-1:0] arr_rd;
   logic [TEST_W-1:0]     word0_lo;

   logic [WORD_WIDTH-1:0] rsp_rd_q;
   logic                  rsp_err_q;
   err_cause_t            cause_q;

   // State register; reset abandons any in-flight request.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state, wait counter and commit strobe.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      commit     = 1'b0;
      use_in     = 1'b0;
      case (state)
         IDLE: begin
            if (Req_Valid) begin
               if (WAIT_CYCLES == 0) begin
                  commit     = 1'b1;
                  use_in     = 1'b1;
                  state_next = RESP;
               end else begin
                  cnt_next   = CNT_W'(WAIT_CYCLES - 1);
                  state_next = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               commit     = 1'b1;
               state_next = RESP;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         RESP: begin
            if (Rsp_Ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Wait-state counter.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

   // Capture the request on acceptance so later input changes are ignored.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         lat_we <= 1'b0;
         lat_a  <= '0;
         lat_wd <= '0;
      end else if (state == IDLE && Req_Valid) begin
         lat_we <= Req_WE;
         lat_a  <= Req_A;
         lat_wd <= Req_WD;
      end
   end

   // With no wait states the commit happens on the accept edge, so the
   // request is taken straight from the inputs instead of the latch.
   always_comb begin
      cmt_we    = use_in ? Req_WE : lat_we;
      cmt_a     = use_in ? Req_A  : lat_a;
      cmt_wd    = use_in ? Req_WD : lat_wd;
      cmt_word  = cmt_a[31:ADDR_LSB];
      err_align = (cmt_a[ADDR_LSB-1:0] != '0);
      err_range = (cmt_word >= WIDX_W'(ENTRIES));
      cmt_err   = err_align | err_range;
      arr_idx   = cmt_word[IDX_W-1:0];
      if (err_align) begin
         cmt_cause = ERR_ALIGN;
      end else if (err_range) begin
         cmt_cause = ERR_RANGE;
      end else begin
         cmt_cause = ERR_NONE;
      end
   end

   dmem_array #(
      .WORD_WIDTH (WORD_WIDTH),
      .ENTRIES    (ENTRIES),
      .IDX_W      (IDX_W)
   ) u_array (
      .Clk      (Clk),
      .Rst      (Rst),
      .wr_en    (commit & cmt_we & ~cmt_err),
      .wr_idx   (arr_idx),
      .wr_data  (cmt_wd),
      .rd_idx   (arr_idx),
      .rd_data  (arr_rd),
      .word0_lo (word0_lo)
   );

   // Response registers: loaded at commit, cleared when consumed.
   always_ff @(posedge Clk) begin
      if (!Rst) begin
         rsp_rd_q  <= '0;
         rsp_err_q <= 1'b0;
         cause_q   <= ERR_NONE;
      end else if (commit) begin
         rsp_rd_q  <= (cmt_err || cmt_we) ? '0 : arr_rd;
         rsp_err_q <= cmt_err;
         cause_q   <= cmt_cause;
      end else if (state == RESP && Rsp_Ready) begin
         rsp_rd_q  <= '0;
         rsp_err_q <= 1'b0;
         cause_q   <= ERR_NONE;
      end
   end

   assign Req_Ready     = (state == IDLE);
   assign Rsp_Valid     = (state == RESP);
   assign Rsp_RD        = rsp_rd_q;
   assign Rsp_Err       = rsp_err_q;
   assign Test_Value    = word0_lo;
   assign dbg_state     = state;
   assign dbg_err_cause = cause_q;

endmodule
